pc_gen: RTL and testbench

Registered, parametrised program-counter generator at the head of the IFU. Each cycle it chooses the next fetch-group address from four sources, in priority order: CSR/trap flush, branch redirect, sequential advance, hold. It presents that address to the I-cache on a valid/ready handshake. Every redirect bumps a fetch epoch, so in-flight responses fetched on a stale path can be dropped downstream. All outputs are registered; there is no combinational path from any input to any output.

---
 rtl/pc_gen.sv | 93 +++++++++
 tb/tb_pc_gen.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-group program counter for the IFU head: picks flush / redirect /
// sequential / hold each cycle and presents the result to the I-cache, fully registered.
module pc_gen #(
  parameter int              XLEN        = 64,
  parameter int              FETCH_WIDTH = 1,
  parameter logic [XLEN-1:0] RESET_PC    = 64'h8000_0000,
  parameter int              EPOCH_W     = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               stall,
  input  logic               flush,
  input  logic [XLEN-1:0]    csr_new_pc_i,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_target,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [XLEN-1:0]    fetch_pc,
  output logic [FETCH_WIDTH-1:0] fetch_mask,
  output logic               fetch_misaligned,
  output logic [EPOCH_W-1:0] fetch_epoch,
  output logic               dbg_state_o
);

  localparam int GB = 4 * FETCH_WIDTH;

  // Handshake: a request transfers on any rising edge where fetch_valid and
  // fetch_ready are both high; while fetch_valid && !fetch_ready the request is
  // held stable unless a flush, redirect or stall withdraws or replaces it.

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q;
  logic                valid_q, valid_d;
  logic [XLEN-1:0]     pc_q, pc_d, seq_pc;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic [FETCH_WIDTH-1:0] mask_q;
  logic                mis_q;

  // Slot i of the group is live iff it sits at or after the entry slot.
  function automatic logic [FETCH_WIDTH-1:0] mask_of(input logic [XLEN-1:0] pc);
    logic [XLEN-1:0] slot;
    slot = (pc >> 2) & XLEN'(FETCH_WIDTH - 1);
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask_of[i] = (XLEN'(i) >= slot);
    end
  endfunction

  assign seq_pc = (pc_q & ~XLEN'(GB - 1)) + XLEN'(GB);

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (flush) begin
      pc_d    = csr_new_pc_i;
      epoch_d = epoch_q + 1'b1;
    end else if (redirect_valid) begin
      pc_d    = redirect_target;
      epoch_d = epoch_q + 1'b1;
    end else if (valid_q && fetch_ready) begin
      pc_d = seq_pc;
    end
  end

  // BOOT always leaves after one cycle, so both states request unless stalled.
  assign valid_d = !stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= BOOT;
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      epoch_q <= '0;
      mask_q  <= mask_of(RESET_PC);
      mis_q   <= 1'b0;
    end else begin
      state_q <= RUN;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      mask_q  <= mask_of(pc_d);
      mis_q   <= (pc_d[1:0] != 2'b00);
    end
  end

  assign fetch_valid      = valid_q;
  assign fetch_pc         = pc_q;
  assign fetch_mask       = mask_q;
  assign fetch_misaligned = mis_q;
  assign fetch_epoch      = epoch_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: FETCH_WIDTH=1 and FETCH_WIDTH=2 instances share
// one stimulus stream; expected values are written out by hand.
module tb_pc_gen;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        flush;
  logic [63:0] csr_new_pc_i;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        fetch_ready;

  logic        v1, v2, mis1, mis2, st1, st2;
  logic [63:0] pc1, pc2;
  logic [0:0]  mask1;
  logic [1:0]  mask2;
  logic [1:0]  ep1, ep2;

  int n_vec = 0;
  int n_err = 0;

  pc_gen #(.FETCH_WIDTH(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .csr_new_pc_i(csr_new_pc_i), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_valid(v1), .fetch_ready(fetch_ready),
    .fetch_pc(pc1), .fetch_mask(mask1), .fetch_misaligned(mis1),
    .fetch_epoch(ep1), .dbg_state_o(st1)
  );

  pc_gen #(.FETCH_WIDTH(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .csr_new_pc_i(csr_new_pc_i), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_valid(v2), .fetch_ready(fetch_ready),
    .fetch_pc(pc2), .fetch_mask(mask2), .fetch_misaligned(mis2),
    .fetch_epoch(ep2), .dbg_state_o(st2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Common checks on both instances for pc, valid and epoch.
  task automatic check_both(input string tag, input logic [63:0] e_pc1, input logic [63:0] e_pc2,
                            input logic e_v, input logic [1:0] e_ep);
    check({tag, " pc1"}, pc1, e_pc1);
    check({tag, " pc2"}, pc2, e_pc2);
    check({tag, " v1"}, 64'(v1), 64'(e_v));
    check({tag, " v2"}, 64'(v2), 64'(e_v));
    check({tag, " ep1"}, 64'(ep1), 64'(e_ep));
    check({tag, " ep2"}, 64'(ep2), 64'(e_ep));
  endtask

  task automatic redirect_to(input logic [63:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    step();
    redirect_valid  = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; stall = 1'b0; flush = 1'b0; csr_new_pc_i = '0;
    redirect_valid = 1'b0; redirect_target = '0; fetch_ready = 1'b1;
    step();
    step();
    check_both("reset", 64'h8000_0000, 64'h8000_0000, 1'b0, 2'd0);
    check("reset mask1", 64'(mask1), 64'h1);
    check("reset mask2", 64'(mask2), 64'h3);
    check("reset mis1", 64'(mis1), 64'h0);
    check("reset state", 64'(st1), 64'h0);

    resetn = 1'b1;
    #1;
    check("boot v1", 64'(v1), 64'h0);
    step();
    check_both("first req", 64'h8000_0000, 64'h8000_0000, 1'b1, 2'd0);
    check("run state", 64'(st2), 64'h1);
    step();
    check_both("seq1", 64'h8000_0004, 64'h8000_0008, 1'b1, 2'd0);
    step();
    check_both("seq2", 64'h8000_0008, 64'h8000_0010, 1'b1, 2'd0);

    redirect_to(64'h8000_0104);
    check_both("redir", 64'h8000_0104, 64'h8000_0104, 1'b1, 2'd1);
    check("redir mask2", 64'(mask2), 64'h2);
    check("redir mask1", 64'(mask1), 64'h1);
    step();
    check_both("redir seq", 64'h8000_0108, 64'h8000_0108, 1'b1, 2'd1);
    check("redir seq mask2", 64'(mask2), 64'h3);

    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_both("not ready", 64'h8000_0108, 64'h8000_0108, 1'b1, 2'd1);
      check("not ready mask2", 64'(mask2), 64'h3);
    end
    fetch_ready = 1'b1;
    step();
    check_both("ready adv", 64'h8000_010c, 64'h8000_0110, 1'b1, 2'd1);

    flush = 1'b1; csr_new_pc_i = 64'h8000_0010;
    redirect_valid = 1'b1; redirect_target = 64'h8000_0200;
    step();
    flush = 1'b0; redirect_valid = 1'b0;
    check_both("flush wins", 64'h8000_0010, 64'h8000_0010, 1'b1, 2'd2);

    for (int i = 0; i < 4; i++) redirect_to(64'h8000_0300);
    check_both("epoch wrap", 64'h8000_0300, 64'h8000_0300, 1'b1, 2'd2);

    fetch_ready = 1'b0; stall = 1'b1;
    step();
    check_both("stall", 64'h8000_0300, 64'h8000_0300, 1'b0, 2'd2);
    redirect_to(64'h8000_0002);
    check_both("stall redir", 64'h8000_0002, 64'h8000_0002, 1'b0, 2'd3);
    check("stall mis1", 64'(mis1), 64'h1);
    stall = 1'b0;
    step();
    check_both("misaligned req", 64'h8000_0002, 64'h8000_0002, 1'b1, 2'd3);
    check("mis2", 64'(mis2), 64'h1);
    check("mis mask2", 64'(mask2), 64'h3);
    fetch_ready = 1'b1;
    step();
    check_both("mis seq", 64'h8000_0004, 64'h8000_0008, 1'b1, 2'd3);
    check("mis seq mis1", 64'(mis1), 64'h0);

    redirect_to(64'hffff_ffff_ffff_fffc);
    check_both("top", 64'hffff_ffff_ffff_fffc, 64'hffff_ffff_ffff_fffc, 1'b1, 2'd0);
    check("top mask2", 64'(mask2), 64'h2);
    step();
    check_both("wrap", 64'h0, 64'h0, 1'b1, 2'd0);
    step();
    check_both("after wrap", 64'h4, 64'h8, 1'b1, 2'd0);

    redirect_to(64'h8000_0400);
    resetn = 1'b0;
    #1;
    check_both("async reset", 64'h8000_0000, 64'h8000_0000, 1'b0, 2'd0);
    step();
    resetn = 1'b1;
    #1;
    check("reboot v2", 64'(v2), 64'h0);
    step();
    check_both("reboot req", 64'h8000_0000, 64'h8000_0000, 1'b1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
